mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 51 +++++
 rtl/arb_fair_counter.sv | 36 +++
 rtl/mem_bus_arbiter.sv | 97 +++++++++
 tb/tb_mem_bus_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types and arbiter state encoding for the fetch/data memory port arbiter.
package mem_bus_arbiter_pkg;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } arb_state_t;

  // A fetch becomes a read of the whole aligned 64-bit word holding the instruction.
  function automatic dbus_req_t fetch_to_dbus(ibus_req_t r);
    dbus_req_t d;
    d.valid  = 1'b1;
    d.addr   = r.addr & ~64'h7;
    d.size   = MSIZE8;
    d.strobe = 8'h00;
    d.data   = 64'h0;
    return d;
  endfunction

endpackage

// File: rtl/arb_fair_counter.sv
// Saturating count of back-to-back data grants taken while a fetch was waiting.
module arb_fair_counter #(
  parameter  int MAX_CONSEC = 4,
  localparam int W          = $clog2(MAX_CONSEC + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam logic [W-1:0] LIMIT = W'(MAX_CONSEC);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != LIMIT)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit_o = (count_q == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between fetch (ibus) and the memory stage (dbus),
// data first, with a bounded run of data grants while a fetch is waiting.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_CONSEC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  oreq,
  input  dbus_resp_t oresp,
  output logic       busy
);

  arb_state_t state_q, state_d;
  dbus_req_t  oreq_q, oreq_d;
  logic       done;
  logic       consec_clr, consec_inc, consec_at_limit;

  arb_fair_counter #(
    .MAX_CONSEC(MAX_CONSEC)
  ) u_fair (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (consec_clr),
    .inc_i     (consec_inc),
    .at_limit_o(consec_at_limit)
  );

  // Downstream only signals completion when address and data phases finish together.
  assign done = oresp.addr_ok & oresp.data_ok;

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    oreq_d     = oreq_q;
    iresp      = '0;
    dresp      = '0;
    consec_clr = 1'b0;
    consec_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        consec_clr = ~ireq.valid;
        if (dreq.valid && (!consec_at_limit || !ireq.valid)) begin
          state_d = GRANT_D;
          oreq_d  = dreq;
        end else if (ireq.valid) begin
          state_d = GRANT_I;
          oreq_d  = fetch_to_dbus(ireq);
        end
      end
      GRANT_D: begin
        dresp.addr_ok = done;
        dresp.data_ok = done;
        dresp.data    = oresp.data;
        if (done) begin
          state_d    = IDLE;
          oreq_d     = '0;
          consec_inc = ireq.valid;
        end
      end
      GRANT_I: begin
        iresp.addr_ok = done;
        iresp.data_ok = done;
        iresp.data    = ireq.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
        if (done) begin
          state_d    = IDLE;
          oreq_d     = '0;
          consec_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        oreq_d  = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      oreq_q  <= '0;
    end else begin
      state_q <= state_d;
      oreq_q  <= oreq_d;
    end
  end

  assign oreq = oreq_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: a per-cycle vector table plus
// hand-built sequences for starvation, mid-transaction reset and a long stall.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  typedef struct {
    logic       rst;
    ibus_req_t  ireq;
    dbus_req_t  dreq;
    dbus_resp_t oresp;
    logic       busy;
    dbus_req_t  oreq;
    ibus_resp_t iresp;
    dbus_resp_t dresp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  oreq;
  dbus_resp_t oresp;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.MAX_CONSEC(4)) dut (
    .clk  (clk),
    .reset(reset),
    .ireq (ireq),
    .iresp(iresp),
    .dreq (dreq),
    .dresp(dresp),
    .oreq (oreq),
    .oresp(oresp),
    .busy (busy)
  );

  always #5 clk = ~clk;

  localparam ibus_req_t  IREQ_A = '{valid: 1'b1, addr: 64'h0000_0000_8000_0004};
  localparam ibus_req_t  IREQ_B = '{valid: 1'b1, addr: 64'h0000_0000_2000_0013};
  localparam dbus_req_t  DREQ_A = '{valid: 1'b1, addr: 64'h100, size: MSIZE4,
                                    strobe: 8'h0F, data: 64'h55};
  localparam dbus_req_t  OREQ_I = '{valid: 1'b1, addr: 64'h0000_0000_8000_0000, size: MSIZE8,
                                    strobe: 8'h00, data: 64'h0};
  localparam dbus_req_t  OREQ_IB = '{valid: 1'b1, addr: 64'h0000_0000_2000_0010, size: MSIZE8,
                                     strobe: 8'h00, data: 64'h0};
  localparam dbus_resp_t RESP1 = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hDEADBEEF_12345678};
  localparam dbus_resp_t RESP2 = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h11223344_55667788};
  localparam dbus_resp_t RESP3 = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hCAFEF00D_0BADF00D};
  localparam dbus_resp_t RESP_S = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hA5A5A5A5_5A5A5A5A};
  localparam ibus_resp_t IRESP1 = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hDEADBEEF};
  localparam ibus_resp_t IRESP3 = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hCAFEF00D};
  localparam ibus_resp_t IRESP_S = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h5A5A5A5A};

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic rst, input ibus_req_t ir, input dbus_req_t dr,
                               input dbus_resp_t orsp, input logic b, input dbus_req_t oq,
                               input ibus_resp_t irsp, input dbus_resp_t drsp);
    vec_t v;
    v.rst   = rst;
    v.ireq  = ir;
    v.dreq  = dr;
    v.oresp = orsp;
    v.busy  = b;
    v.oreq  = oq;
    v.iresp = irsp;
    v.dresp = drsp;
    return v;
  endfunction

  // Drive one cycle of inputs mid-cycle, then compare all outputs before the next edge.
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    reset = v.rst;
    ireq  = v.ireq;
    dreq  = v.dreq;
    oresp = v.oresp;
    #1;
    check({tag, ".busy"},  192'(busy),  192'(v.busy));
    check({tag, ".oreq"},  192'(oreq),  192'(v.oreq));
    check({tag, ".iresp"}, 192'(iresp), 192'(v.iresp));
    check({tag, ".dresp"}, 192'(dresp), 192'(v.dresp));
  endtask

  vec_t tbl[13];
  vec_t v;
  logic is_i;

  initial begin
    // Rows: reset state, lone fetch, then simultaneous fetch+data with data first.
    tbl[0]  = mkv(1'b1, '0,     '0,     '0,    1'b0, '0,     '0,     '0);
    tbl[1]  = mkv(1'b0, IREQ_A, '0,     '0,    1'b0, '0,     '0,     '0);
    tbl[2]  = mkv(1'b0, IREQ_A, '0,     '0,    1'b1, OREQ_I, '0,     '0);
    tbl[3]  = mkv(1'b0, IREQ_A, '0,     '0,    1'b1, OREQ_I, '0,     '0);
    tbl[4]  = mkv(1'b0, IREQ_A, '0,     RESP1, 1'b1, OREQ_I, IRESP1, '0);
    tbl[5]  = mkv(1'b0, '0,     '0,     '0,    1'b0, '0,     '0,     '0);
    tbl[6]  = mkv(1'b0, IREQ_A, DREQ_A, '0,    1'b0, '0,     '0,     '0);
    tbl[7]  = mkv(1'b0, IREQ_A, DREQ_A, '0,    1'b1, DREQ_A, '0,     '0);
    tbl[8]  = mkv(1'b0, IREQ_A, DREQ_A, RESP2, 1'b1, DREQ_A, '0,     RESP2);
    tbl[9]  = mkv(1'b0, IREQ_A, '0,     '0,    1'b0, '0,     '0,     '0);
    tbl[10] = mkv(1'b0, IREQ_A, '0,     '0,    1'b1, OREQ_I, '0,     '0);
    tbl[11] = mkv(1'b0, IREQ_A, '0,     RESP3, 1'b1, OREQ_I, IRESP3, '0);
    tbl[12] = mkv(1'b0, '0,     '0,     '0,    1'b0, '0,     '0,     '0);

    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 13; i++) begin
      step($sformatf("tbl%0d", i), tbl[i]);
    end

    // Data held valid with a fetch pending: expect grants D,D,D,D,I,D.
    for (int g = 0; g < 6; g++) begin
      is_i = (g == 4);
      v = mkv(1'b0, IREQ_B, DREQ_A, '0, 1'b0, '0, '0, '0);
      step($sformatf("starve%0d.idle", g), v);
      if (g == 4) check("starve.consec_at_limit", 192'(dut.u_fair.count_q), 192'(3'd4));
      if (g == 5) check("starve.consec_after_i", 192'(dut.u_fair.count_q), 192'(3'd0));
      v.oresp = RESP_S;
      v.busy  = 1'b1;
      v.oreq  = is_i ? OREQ_IB : DREQ_A;
      v.iresp = is_i ? IRESP_S : ibus_resp_t'('0);
      v.dresp = is_i ? dbus_resp_t'('0) : RESP_S;
      step($sformatf("starve%0d.grant", g), v);
    end

    // Reset one cycle into a data grant, then a pending fetch proceeds normally.
    step("rst.idle",    mkv(1'b0, IREQ_A, DREQ_A, '0,    1'b0, '0,     '0,     '0));
    step("rst.grant_d", mkv(1'b1, IREQ_A, DREQ_A, '0,    1'b1, DREQ_A, '0,     '0));
    step("rst.after",   mkv(1'b0, IREQ_A, '0,     '0,    1'b0, '0,     '0,     '0));
    check("rst.state", 192'(dut.state_q), 192'(IDLE));
    step("rst.grant_i", mkv(1'b0, IREQ_A, '0,     '0,    1'b1, OREQ_I, '0,     '0));
    step("rst.done_i",  mkv(1'b0, IREQ_A, '0,     RESP1, 1'b1, OREQ_I, IRESP1, '0));

    // Downstream stalls for ten cycles while the data requester drops valid early.
    step("stall.idle", mkv(1'b0, '0, DREQ_A, '0, 1'b0, '0, '0, '0));
    for (int k = 0; k < 10; k++) begin
      v = mkv(1'b0, '0, DREQ_A, '0, 1'b1, DREQ_A, '0, '0);
      v.dreq.valid = (k < 3);
      if (k == 9) begin
        v.oresp = RESP2;
        v.dresp = RESP2;
      end
      step($sformatf("stall%0d", k), v);
    end
    step("stall.after", mkv(1'b0, '0, '0, '0, 1'b0, '0, '0, '0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
